// File: rtl/rv_core_pkg.sv
// Shared constants for the RV32 core and its memory sequencer:
// opcodes, sequencer state encoding and the reset instruction.
package rv_core_pkg;

   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam logic [2:0]  S_IDLE    = 3'd0;
   localparam logic [2:0]  S_FETCH   = 3'd1;
   localparam logic [2:0]  S_DATA    = 3'd2;
   localparam logic [2:0]  S_STEP    = 3'd3;
   localparam logic [2:0]  S_FAULT   = 3'd4;

   function automatic logic is_mem_op(input logic [6:0] opcode);
      return (opcode == OP_LOAD) || (opcode == OP_STORE);
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating wait-cycle counter for the memory handshake; expired is the
// terminal count (never asserted when TIMEOUT is 0).
module bus_watchdog #(
   parameter int TIMEOUT = 16,
   parameter int TW      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + TW'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && (count == TW'(TIMEOUT));

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer sharing one single-ported memory between fetch and
// load/store for a single-cycle RV32 core; pulses o_step to commit.
module mem_sequencer
   import rv_core_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TW      = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_run,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_alu,
   input  logic [31:0] i_dmem,
   input  logic        i_wmem,
   output logic [31:0] o_instr,
   output logic [31:0] o_rdata,
   output logic        o_step,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy,
   output logic        o_fault
);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       in_bus;
   logic       timed_out;

   assign in_bus = (state == S_FETCH) || (state == S_DATA);

   // Counter is held at zero outside bus states, so every FETCH/DATA entry starts fresh.
   bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_watchdog (
      .clk     (i_clk),
      .reset   (i_reset),
      .clear   (!in_bus || i_mem_ack),
      .enable  (in_bus && !i_mem_ack),
      .expired (timed_out)
   );

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_run) state_nxt = S_FETCH;
         S_FETCH: begin
            if (i_mem_ack)      state_nxt = is_mem_op(i_mem_rdata[6:0]) ? S_DATA : S_STEP;
            else if (timed_out) state_nxt = S_FAULT;
         end
         S_DATA: begin
            if (i_mem_ack)      state_nxt = S_STEP;
            else if (timed_out) state_nxt = S_FAULT;
         end
         S_STEP:  state_nxt = i_run ? S_FETCH : S_IDLE;
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= S_IDLE;
         o_instr <= NOP_INSTR;
         o_rdata <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_FETCH) && i_mem_ack) begin
            o_instr <= i_mem_rdata;
         end
         if ((state == S_DATA) && i_mem_ack && (o_instr[6:0] == OP_LOAD)) begin
            o_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_mem_req   = in_bus;
   assign o_mem_we    = (state == S_DATA) && (o_instr[6:0] == OP_STORE) && i_wmem;
   assign o_mem_addr  = (state == S_DATA) ? i_alu : i_pc;
   assign o_mem_wdata = i_dmem;
   assign o_step      = (state == S_STEP);
   assign o_fault     = (state == S_FAULT);
   assign o_busy      = (state != S_IDLE) && (state != S_FAULT);

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: directed scenarios plus randomized instructions,
// checked against a per-instruction transaction model of the cycle sequence.
module tb_mem_sequencer;

   localparam logic [6:0]  LOAD_OP  = 7'h03;
   localparam logic [6:0]  STORE_OP = 7'h23;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic        clk = 1'b0;
   logic        i_reset, i_run, i_wmem, i_mem_ack;
   logic [31:0] i_pc, i_alu, i_dmem, i_mem_rdata;
   logic [31:0] o_instr, o_rdata, o_mem_addr, o_mem_wdata;
   logic        o_step, o_mem_req, o_mem_we, o_busy, o_fault;

   int          checks = 0;
   int          passed = 0;
   logic [31:0] exp_instr;
   logic [31:0] exp_rdata;
   logic [31:0] pc;

   always #5 clk = ~clk;

   mem_sequencer #(.TIMEOUT(4), .TW(8)) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_run       (i_run),
      .i_pc        (i_pc),
      .i_alu       (i_alu),
      .i_dmem      (i_dmem),
      .i_wmem      (i_wmem),
      .o_instr     (o_instr),
      .o_rdata     (o_rdata),
      .o_step      (o_step),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata),
      .o_busy      (o_busy),
      .o_fault     (o_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_outs(input string tag, input logic req, input logic we,
                              input logic [31:0] addr, input logic step,
                              input logic busy, input logic fault);
      chk({tag, ".req"},   32'(o_mem_req), 32'(req));
      chk({tag, ".we"},    32'(o_mem_we),  32'(we));
      chk({tag, ".addr"},  o_mem_addr,     addr);
      chk({tag, ".step"},  32'(o_step),    32'(step));
      chk({tag, ".busy"},  32'(o_busy),    32'(busy));
      chk({tag, ".fault"}, 32'(o_fault),   32'(fault));
   endtask

   // Transaction model: FETCH for wf+1 cycles, DATA for wd+1 cycles when the
   // instruction is a load/store, then one STEP cycle. Entered with the DUT in FETCH.
   task automatic run_instr(input logic [31:0] instr, input logic [31:0] ipc,
                            input logic [31:0] alu, input logic [31:0] dmem,
                            input logic wmem, input int wf, input int wd,
                            input logic [31:0] ldata, input bit drop_run);
      bit is_load, is_store;
      is_load  = (instr[6:0] == LOAD_OP);
      is_store = (instr[6:0] == STORE_OP);
      i_pc = ipc; i_alu = alu; i_dmem = dmem; i_wmem = wmem;
      for (int k = 0; k <= wf; k++) begin
         i_mem_ack   = (k == wf);
         i_mem_rdata = (k == wf) ? instr : $urandom;
         #1;
         expect_outs("fetch", 1'b1, 1'b0, ipc, 1'b0, 1'b1, 1'b0);
         chk("fetch.instr_hold", o_instr, exp_instr);
         chk("fetch.wdata", o_mem_wdata, dmem);
         tick();
      end
      exp_instr = instr;
      if (is_load || is_store) begin
         for (int k = 0; k <= wd; k++) begin
            i_mem_ack   = (k == wd);
            i_mem_rdata = (k == wd) ? ldata : $urandom;
            if (drop_run && k == 0) i_run = 1'b0;
            #1;
            expect_outs("data", 1'b1, is_store && wmem, alu, 1'b0, 1'b1, 1'b0);
            chk("data.wdata", o_mem_wdata, dmem);
            chk("data.instr", o_instr, exp_instr);
            tick();
         end
         if (is_load) exp_rdata = ldata;
      end
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
      #1;
      expect_outs("step", 1'b0, 1'b0, ipc, 1'b1, 1'b1, 1'b0);
      chk("step.instr", o_instr, exp_instr);
      chk("step.rdata", o_rdata, exp_rdata);
      tick();
   endtask

   initial begin
      logic [6:0]  opc;
      logic [31:0] instr;
      i_reset = 1'b1; i_run = 1'b0; i_pc = '0; i_alu = '0; i_dmem = '0;
      i_wmem = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
      tick(); tick();
      #1;
      expect_outs("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("reset.instr", o_instr, NOP);
      chk("reset.rdata", o_rdata, 32'h0);
      exp_instr = NOP;
      exp_rdata = '0;

      // ADDI at pc 0 with zero-wait memory, then the next fetch at pc 4.
      i_reset = 1'b0; i_run = 1'b1;
      tick();
      run_instr(32'h00100093, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
      // LW from 0x100 with two wait cycles.
      run_instr(32'h10002083, 32'h4, 32'h100, 32'h0, 1'b0, 0, 2, 32'hDEADBEEF, 1'b0);
      // SW to 0x200 with one wait cycle in each phase.
      run_instr(32'h20102023, 32'h8, 32'h200, 32'h12345678, 1'b1, 1, 1, 32'h0, 1'b0);
      // Ack arriving on the terminal watchdog cycle wins over the timeout.
      run_instr(32'h00208113, 32'hC, 32'h0, 32'h0, 1'b0, 4, 0, 32'h0, 1'b0);

      pc = 32'h10;
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       opc = LOAD_OP;
            1:       opc = STORE_OP;
            2:       opc = 7'h33;
            default: opc = 7'h13;
         endcase
         instr = {$urandom_range(0, 32'h01FFFFFF), opc};
         run_instr(instr, pc, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom, 1'b0);
         pc = pc + 32'd4;
      end

      // Run dropped during the DATA wait of a load: the load completes, then IDLE.
      run_instr(32'h00002183, pc, 32'h300, 32'h0, 1'b0, 0, 2, 32'hCAFEF00D, 1'b1);
      for (int k = 0; k < 2; k++) begin
         #1;
         expect_outs("idle", 1'b0, 1'b0, pc, 1'b0, 1'b0, 1'b0);
         tick();
      end
      pc = 32'h400;
      i_pc = pc; i_run = 1'b1;
      tick();
      run_instr(32'h00000013, pc, 32'h0, 32'h0, 1'b0, 1, 0, 32'h0, 1'b0);

      // No ack in FETCH: five request cycles, then a sticky fault.
      pc = 32'h404;
      i_pc = pc; i_mem_ack = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         expect_outs("wait", 1'b1, 1'b0, pc, 1'b0, 1'b1, 1'b0);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         i_mem_ack = 1'(k);
         #1;
         expect_outs("fault", 1'b0, 1'b0, pc, 1'b0, 1'b0, 1'b1);
         tick();
      end
      i_mem_ack = 1'b0; i_reset = 1'b1;
      tick();
      i_reset = 1'b0; i_run = 1'b0;
      #1;
      expect_outs("fault_reset", 1'b0, 1'b0, pc, 1'b0, 1'b0, 1'b0);
      exp_instr = NOP;
      exp_rdata = '0;

      // Reset during a FETCH wait after a load has left non-reset latches.
      i_run = 1'b1; pc = 32'h0;
      tick();
      run_instr(32'h00802203, pc, 32'h8, 32'h0, 1'b0, 0, 0, 32'h5A5A1234, 1'b0);
      i_pc = 32'h4; i_mem_ack = 1'b0;
      #1;
      expect_outs("prereset", 1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 1'b0);
      i_reset = 1'b1; i_run = 1'b0;
      tick();
      i_reset = 1'b0;
      #1;
      expect_outs("midreset", 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);
      chk("midreset.instr", o_instr, NOP);
      chk("midreset.rdata", o_rdata, 32'h0);
      tick();
      #1;
      expect_outs("midreset_idle", 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
